// File: rtl/instruction_prefetch_unit_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package instruction_prefetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  localparam int unsigned INSTR_STRIDE = 4;
  localparam int unsigned ALIGN_BITS   = 2;

endpackage

// File: rtl/instruction_prefetch_unit_if.sv
// Fetch-side memory bus: prefetch unit is master, instruction memory is slave.
interface instruction_prefetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ready,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ready,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/instruction_prefetch_unit_sync_fifo.sv
// Synchronous FIFO with flush; head word is visible combinationally on data_o.
module sync_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Sequential instruction prefetcher: one outstanding fetch, queued {pc, instr}
// entries, and head-relative branch redirect with stale-response discard.
module instruction_prefetch_unit
  import instruction_prefetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  instruction_prefetch_unit_if.master  mem,
  output logic                         instr_valid_o,
  output logic [XLEN-1:0]              instr_out_o,
  output logic [XLEN-1:0]              instr_pc_o,
  input  logic                         instr_pop_i,
  input  logic                         branch_enable_i,
  input  logic [XLEN-1:0]              immediate_i
);

  localparam int unsigned     CW         = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'((1 << ALIGN_BITS) - 1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;

  logic            mem_req_c;
  logic            push_c;
  logic            pop_c;
  logic            redirect_c;
  logic [XLEN-1:0] target_c;
  logic [CW-1:0]   fifo_count;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_instr;

  sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_c),
    .data_i  ({req_addr_q, mem.mem_rdata}),
    .pop_i   (pop_c),
    .flush_i (redirect_c),
    .data_o  ({head_pc, head_instr}),
    .count_o (fifo_count)
  );

  assign instr_valid_o = (fifo_count != '0);
  assign instr_pc_o    = instr_valid_o ? head_pc    : '0;
  assign instr_out_o   = instr_valid_o ? head_instr : '0;

  // A redirect flushes the queue, so it also cancels any same-cycle pop
  assign redirect_c = branch_enable_i && instr_valid_o;
  assign target_c   = (instr_pc_o + immediate_i) & ALIGN_MASK;
  assign pop_c      = instr_pop_i && instr_valid_o && !redirect_c;

  assign mem.mem_req  = mem_req_c;
  assign mem.mem_addr = fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    mem_req_c  = 1'b0;
    push_c     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req_c = (fifo_count < CW'(DEPTH));
        if (mem_req_c && mem.mem_ready) begin
          req_addr_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + XLEN'(INSTR_STRIDE);
          // Request accepted alongside a redirect already fetches the wrong path
          state_d    = redirect_c ? ST_DISCARD : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_c) begin
          state_d = mem.mem_rvalid ? ST_FETCH : ST_DISCARD;
        end else if (mem.mem_rvalid) begin
          push_c  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (mem.mem_rvalid) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    if (redirect_c) fetch_pc_d = target_c;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Randomized scoreboard bench for instruction_prefetch_unit against a queue-level model.
module tb_instruction_prefetch_unit;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        rst_i;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_pop;
  logic        branch_enable;
  logic [31:0] immediate;

  instruction_prefetch_unit_if #(.XLEN(XLEN)) mem_if ();

  instruction_prefetch_unit #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .mem             (mem_if),
    .instr_valid_o   (instr_valid),
    .instr_out_o     (instr_out),
    .instr_pc_o      (instr_pc),
    .instr_pop_i     (instr_pop),
    .branch_enable_i (branch_enable),
    .immediate_i     (immediate)
  );

  always #5 clk = ~clk;

  // Reference model state
  ent_t        model_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] nxt_addr;
  bit          out_valid, out_stale, late_pending, just_reset, mon_en;
  logic [31:0] out_addr;
  int          out_delay;

  // Inputs planned for the coming edge
  bit          d_rst, d_ready, d_rvalid, d_pop, d_branch, d_accept, d_resp_real, d_taken;
  logic [31:0] d_imm, d_rdata, d_target;

  // Stimulus knobs
  bit rst_req;
  int p_ready, p_pop, p_br, p_spur, p_rst_pm, lat_min, lat_max;

  int n_checks;
  int n_fail;

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] pick_imm();
    case ($urandom_range(5))
      0:       return 32'hFFFF_FFF4;
      1:       return 32'h0000_0006;
      2:       return 32'h0000_0020;
      3:       return 32'hFFFF_FFF8;
      4:       return 32'($urandom_range(64)) - 32'd32;
      default: return $urandom;
    endcase
  endfunction

  // Apply the effect of the inputs that were presented at the edge just taken
  task automatic commit();
    if (d_rst) begin
      late_pending = out_valid;
      model_q.delete();
      out_valid  = 0;
      nxt_addr   = RESET_PC;
      just_reset = 1;
      mon_en     = 1;
    end else begin
      just_reset = 0;
      if (d_resp_real) begin
        if (!out_stale && !d_taken) model_q.push_back('{pc: out_addr, instr: fdata(out_addr)});
        out_valid = 0;
      end
      if (d_accept) begin
        out_valid = 1;
        out_addr  = nxt_addr;
        out_stale = d_taken;
        out_delay = $urandom_range(lat_max, lat_min);
        nxt_addr  = nxt_addr + 32'd4;
      end
      if (d_taken) begin
        model_q.delete();
        nxt_addr  = d_target;
        out_stale = 1;
      end
    end
  endtask

  task automatic choose();
    d_rst    = rst_req || ($urandom_range(999) < p_rst_pm);
    d_ready  = ($urandom_range(99) < p_ready);
    d_accept = !d_rst && (mem_if.mem_req === 1'b1) && d_ready;
    if (d_accept) exp_addr_q.push_back(nxt_addr);
    d_resp_real = 0;
    d_rvalid    = 0;
    d_rdata     = $urandom;
    if (out_valid) begin
      if (out_delay == 0) begin
        d_resp_real = 1;
        d_rvalid    = 1;
        d_rdata     = fdata(out_addr);
      end else begin
        out_delay--;
      end
    end else if (late_pending) begin
      d_rvalid     = 1;
      late_pending = 0;
    end else begin
      d_rvalid = ($urandom_range(99) < p_spur);
    end
    d_pop    = ($urandom_range(99) < p_pop);
    d_branch = ($urandom_range(99) < p_br);
    d_imm    = pick_imm();
    d_taken  = !d_rst && d_branch && (model_q.size() != 0);
    d_target = d_taken ? ((model_q[0].pc + d_imm) & 32'hFFFF_FFFC) : 32'h0;

    rst_i             = d_rst;
    mem_if.mem_ready  = d_ready;
    mem_if.mem_rvalid = d_rvalid;
    mem_if.mem_rdata  = d_rdata;
    instr_pop         = d_pop;
    branch_enable     = d_branch;
    immediate         = d_imm;
  endtask

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    commit();
    choose();
  endtask

  // Monitor: compares presented outputs against the model and retires popped entries
  always @(negedge clk) begin
    if (mon_en) begin
      check("instr_valid", 32'(instr_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) begin
        check("instr_pc", instr_pc, model_q[0].pc);
        check("instr_out", instr_out, model_q[0].instr);
      end
      if (just_reset) begin
        check("reset_instr_pc", instr_pc, 32'h0);
        check("reset_instr_out", instr_out, 32'h0);
        check("reset_mem_addr", mem_if.mem_addr, RESET_PC);
      end
      check("mem_req", 32'(mem_if.mem_req), 32'(!out_valid && (model_q.size() < DEPTH)));
      if (!d_rst && mem_if.mem_req === 1'b1 && d_ready) begin
        if (exp_addr_q.size() == 0) begin
          check("mem_addr_unexpected", mem_if.mem_addr, 32'hDEAD_BEEF);
        end else begin
          check("mem_addr", mem_if.mem_addr, exp_addr_q.pop_front());
        end
      end
      if (!d_rst && !d_taken && d_pop && model_q.size() != 0) void'(model_q.pop_front());
    end
  end

  initial begin
    clk = 0;
    n_checks = 0;
    n_fail = 0;
    nxt_addr = RESET_PC;
    out_valid = 0;
    out_stale = 0;
    late_pending = 0;
    just_reset = 0;
    mon_en = 0;
    out_delay = 0;
    out_addr = '0;
    d_rst = 1;
    d_ready = 0;
    d_rvalid = 0;
    d_pop = 0;
    d_branch = 0;
    d_accept = 0;
    d_resp_real = 0;
    d_taken = 0;
    d_imm = '0;
    d_rdata = '0;
    d_target = '0;
    rst_req = 1;
    p_ready = 0;
    p_pop = 0;
    p_br = 0;
    p_spur = 0;
    p_rst_pm = 0;
    lat_min = 0;
    lat_max = 0;
    rst_i = 1;
    mem_if.mem_ready = 0;
    mem_if.mem_rvalid = 0;
    mem_if.mem_rdata = '0;
    instr_pop = 0;
    branch_enable = 0;
    immediate = '0;

    repeat (2) drive_cycle();
    rst_req = 0;

    // Fill with always-ready memory and one-cycle response, no consumer
    p_ready = 100;
    repeat (16) drive_cycle();

    // Drain while refilling: pop every cycle
    p_pop = 100;
    repeat (40) drive_cycle();

    // Mixed random traffic with redirects, stray responses and occasional resets
    p_ready = 70; p_pop = 40; p_br = 8; p_spur = 15; p_rst_pm = 3;
    lat_min = 0; lat_max = 3;
    repeat (4000) drive_cycle();

    // Branch-heavy traffic with slow responses to exercise discard
    p_br = 30; lat_min = 2; lat_max = 4; p_rst_pm = 0;
    repeat (1500) drive_cycle();

    // Reset while a fetch is outstanding; its late response must be ignored
    p_br = 0; p_spur = 0; lat_min = 3; lat_max = 3;
    begin
      int waited = 0;
      while (!(out_valid && out_delay > 0) && waited < 50) begin
        drive_cycle();
        waited++;
      end
      if (waited >= 50) check("wait_outstanding_timeout", 32'(waited), 32'd0);
    end
    rst_req = 1;
    drive_cycle();
    rst_req = 0;
    p_ready = 0;
    repeat (3) drive_cycle();
    p_ready = 100; p_pop = 50; lat_min = 0; lat_max = 1;
    repeat (30) drive_cycle();

    @(negedge clk);
    #1;
    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
